// File: rtl/sub_serial.sv
// Bit-serial subtractor: loads a and b (optionally unmasked), then shifts out
// a - b LSB-first into out over WIDTH clocks and reports the final borrow.
module sub_serial #(
  parameter int               WIDTH  = 8,
  parameter logic [WIDTH-1:0] A_MASK = '0,
  parameter logic [WIDTH-1:0] B_MASK = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic             borrow,
  output logic             done,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [CW-1:0]    count;
  logic             diff_bit;
  logic             borrow_n;

  // Handshake: en is a start request; it is taken only while busy is low
  // (IDLE), and the result is valid in out/borrow for the single cycle done=1.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (en) state_n = SUB;
      SUB:     if (count == LAST) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    diff_bit = a_reg[0] ^ b_reg[0] ^ borrow;
    borrow_n = (~a_reg[0] & b_reg[0]) | (~a_reg[0] & borrow) | (b_reg[0] & borrow);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      a_reg  <= '0;
      b_reg  <= '0;
      out    <= '0;
      borrow <= 1'b0;
      count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            a_reg  <= a ^ A_MASK;
            b_reg  <= b ^ B_MASK;
            out    <= '0;
            borrow <= 1'b0;
            count  <= '0;
          end
        end
        SUB: begin
          out    <= {diff_bit, out[WIDTH-1:1]};
          borrow <= borrow_n;
          a_reg  <= a_reg >> 1;
          b_reg  <= b_reg >> 1;
          count  <= count + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign done      = (state == DONE);
  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule
